// File: rtl/hack_cpu_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : hack_cpu_ctrl
//  Brief    : Multi-cycle Hack CPU control stage. Fetches instructions over a
//             ROM req/valid handshake, decodes A/C instructions, drives the
//             external combinational ALU and performs M reads/writes over a
//             RAM req/ready handshake. Owns the A, D and PC registers.
//  Revision : 1.0 - initial release
// ============================================================================
module hack_cpu_ctrl #(
  parameter logic [14:0] RESET_PC = 15'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        rom_req,
  output logic [14:0] rom_addr,
  input  logic [15:0] rom_data,
  input  logic        rom_valid,
  output logic        ram_rd,
  output logic        ram_wr,
  output logic [14:0] ram_addr,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  input  logic        ram_ready,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic [5:0]  alu_ctl,
  input  logic [15:0] alu_out,
  input  logic        alu_zero,
  input  logic        alu_neg,
  output logic [14:0] pc,
  output logic [15:0] a_reg,
  output logic [15:0] d_reg
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_MEM_RD = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_MEM_WR = 3'd5;

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [15:0] ir;
  logic [15:0] m_lat;
  logic [14:0] waddr;
  logic [15:0] wdata;
  logic [14:0] pc_inc;
  logic        jump_take;

  // Natural 15-bit overflow gives the 7FFF -> 0000 wrap.
  assign pc_inc    = pc + 15'd1;
  assign jump_take = (ir[2] & alu_neg) | (ir[1] & alu_zero) | (ir[0] & ~alu_neg & ~alu_zero);

  assign rom_addr  = pc;
  assign ram_wdata = wdata;
  assign alu_x     = d_reg;
  assign alu_y     = ir[12] ? m_lat : a_reg;
  assign alu_ctl   = ir[11:6];

  // State register; async reset returns to IDLE so all requests drop at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: handshake states wait for their own completion only.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   state_nxt = S_FETCH;
      S_FETCH:  if (rom_valid) state_nxt = S_DECODE;
      S_DECODE: begin
        if (!ir[15])     state_nxt = S_FETCH;
        else if (ir[12]) state_nxt = S_MEM_RD;
        else             state_nxt = S_EXEC;
      end
      S_MEM_RD: if (ram_ready) state_nxt = S_EXEC;
      S_EXEC:   state_nxt = ir[3] ? S_MEM_WR : S_FETCH;
      S_MEM_WR: if (ram_ready) state_nxt = S_FETCH;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Request outputs decoded from state alone, hence mutually exclusive.
  always_comb begin
    rom_req  = 1'b0;
    ram_rd   = 1'b0;
    ram_wr   = 1'b0;
    ram_addr = a_reg[14:0];
    case (state)
      S_FETCH:  rom_req = 1'b1;
      S_MEM_RD: ram_rd  = 1'b1;
      S_MEM_WR: begin
        ram_wr   = 1'b1;
        ram_addr = waddr;
      end
      default: ;
    endcase
  end

  // Architectural and pipeline registers; EXEC uses the pre-update A throughout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      a_reg <= 16'h0000;
      d_reg <= 16'h0000;
      ir    <= 16'h0000;
      m_lat <= 16'h0000;
      waddr <= 15'h0000;
      wdata <= 16'h0000;
    end else begin
      case (state)
        S_FETCH:  if (rom_valid) ir <= rom_data;
        S_DECODE: begin
          if (!ir[15]) begin
            a_reg <= ir;
            pc    <= pc_inc;
          end
        end
        S_MEM_RD: if (ram_ready) m_lat <= ram_rdata;
        S_EXEC: begin
          if (ir[5]) a_reg <= alu_out;
          if (ir[4]) d_reg <= alu_out;
          if (ir[3]) begin
            waddr <= a_reg[14:0];
            wdata <= alu_out;
          end
          pc <= jump_take ? a_reg[14:0] : pc_inc;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hack_cpu_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_hack_cpu_ctrl
//  Brief    : Scoreboard bench for hack_cpu_ctrl with ROM/RAM/ALU models.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hack_cpu_ctrl;

  localparam int K_FETCH = 0;
  localparam int K_END   = 1;
  localparam int K_WR    = 2;
  localparam int K_RD    = 3;

  typedef struct {
    int          kind;
    int          cyc;
    logic [15:0] p0;
    logic [15:0] p1;
    logic [15:0] p2;
    int          held;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rom_req, ram_rd, ram_wr, rom_valid, ram_ready;
  logic [14:0] rom_addr, ram_addr, pc;
  logic [15:0] rom_data, ram_wdata, ram_rdata;
  logic [15:0] alu_x, alu_y, alu_out, a_reg, d_reg;
  logic [5:0]  alu_ctl;
  logic        alu_zero, alu_neg;

  always #5 clk = ~clk;

  hack_cpu_ctrl #(.RESET_PC(15'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .rom_req(rom_req), .rom_addr(rom_addr), .rom_data(rom_data), .rom_valid(rom_valid),
    .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ready(ram_ready),
    .alu_x(alu_x), .alu_y(alu_y), .alu_ctl(alu_ctl), .alu_out(alu_out),
    .alu_zero(alu_zero), .alu_neg(alu_neg),
    .pc(pc), .a_reg(a_reg), .d_reg(d_reg)
  );

  // Reference Hack ALU
  function automatic logic [15:0] alu_model(input logic [15:0] x, input logic [15:0] y,
                                            input logic [5:0] c);
    logic [15:0] xx, yy, o;
    xx = c[5] ? 16'h0000 : x;
    if (c[4]) xx = ~xx;
    yy = c[3] ? 16'h0000 : y;
    if (c[2]) yy = ~yy;
    o = c[1] ? (xx + yy) : (xx & yy);
    if (c[0]) o = ~o;
    return o;
  endfunction

  assign alu_out  = alu_model(alu_x, alu_y, alu_ctl);
  assign alu_zero = (alu_out == 16'h0000);
  assign alu_neg  = alu_out[15];

  int   total = 0;
  int   passed = 0;
  int   cyc;
  exp_t exp_q[$];

  // Program served strictly in order, so re-fetching a used address stalls.
  logic [14:0] prog_addr [16];
  logic [15:0] prog_data [16];
  int          prog_len = 0;
  int          rom_idx;
  int          ram_delay = 0;
  int          ram_cnt;
  logic [15:0] mem [32768];
  logic [14:0] pre_addr = 15'd0;
  logic [15:0] pre_val = 16'h0000;
  bit          mem_init_done = 1'b0;
  bit          end_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
  endtask

  task automatic flag(input string name, input int what);
    total++;
    $display("FAIL %s: got %0d expected none", name, what);
  endtask

  task automatic add(input logic [14:0] a, input logic [15:0] d);
    prog_addr[prog_len] = a;
    prog_data[prog_len] = d;
    prog_len++;
  endtask

  task automatic push_f(input int kind, input int c, input logic [14:0] p,
                        input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    e.kind = kind; e.cyc = c; e.p0 = 16'(p); e.p1 = a; e.p2 = d; e.held = 0;
    exp_q.push_back(e);
  endtask

  task automatic push_m(input int kind, input int c, input logic [14:0] addr,
                        input logic [15:0] data, input int held);
    exp_t e;
    e.kind = kind; e.cyc = c; e.p0 = 16'(addr); e.p1 = data; e.p2 = 16'h0; e.held = held;
    exp_q.push_back(e);
  endtask

  task automatic take_event(input int kind, input logic [15:0] p0, input logic [15:0] p1,
                            input logic [15:0] p2, input int held);
    exp_t e;
    if (exp_q.size() == 0) begin
      flag("unexpected_event_kind", kind);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", 32'(kind), 32'(e.kind));
      if (e.cyc >= 0) chk($sformatf("event%0d_cycle", kind), 32'(cyc), 32'(e.cyc));
      if (kind == K_FETCH || kind == K_END) begin
        chk($sformatf("event%0d_pc", kind), 32'(p0), 32'(e.p0));
        chk($sformatf("event%0d_a", kind), 32'(p1), 32'(e.p1));
        chk($sformatf("event%0d_d", kind), 32'(p2), 32'(e.p2));
      end else begin
        chk($sformatf("event%0d_addr", kind), 32'(p0), 32'(e.p0));
        chk($sformatf("event%0d_data", kind), 32'(p1), 32'(e.p1));
        chk($sformatf("event%0d_held", kind), 32'(held), 32'(e.held));
      end
    end
  endtask

  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  // Memory models: responses for the coming rising edge are set on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      if (!mem_init_done) begin
        for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
        mem_init_done = 1'b1;
      end
      mem[pre_addr] = pre_val;
      rom_idx   = 0;
      rom_valid = 1'b0;
      rom_data  = 16'h0000;
      ram_ready = 1'b0;
      ram_rdata = 16'h0000;
      ram_cnt   = 0;
    end else begin
      rom_valid = 1'b0;
      rom_data  = 16'h0000;
      if (rom_req && rom_idx < prog_len && prog_addr[rom_idx] == rom_addr) begin
        rom_valid = 1'b1;
        rom_data  = prog_data[rom_idx];
        rom_idx++;
      end
      ram_ready = 1'b0;
      ram_rdata = mem[ram_addr];
      if (ram_rd || ram_wr) begin
        if (ram_cnt == ram_delay) begin
          ram_ready = 1'b1;
          ram_cnt   = 0;
          if (ram_wr) mem[ram_addr] = ram_wdata;
        end else begin
          ram_cnt++;
        end
      end else begin
        ram_cnt = 0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT completes a transfer.
  int          wr_cyc = 0, rd_cyc = 0;
  bit          y_pend = 1'b0;
  logic [15:0] y_exp = 16'h0, wr_d0 = 16'h0;
  logic [14:0] wr_a0 = 15'h0;
  always begin
    @(negedge clk); #1;
    if (!rst_n) begin
      wr_cyc = 0; rd_cyc = 0; y_pend = 1'b0; end_seen = 1'b0;
    end else begin
      if (y_pend) begin
        chk("exec_alu_y", 32'(alu_y), 32'(y_exp));
        y_pend = 1'b0;
      end
      if ((rom_req && (ram_rd || ram_wr)) || (ram_rd && ram_wr))
        flag("req_exclusive", int'({rom_req, ram_rd, ram_wr}));
      if (rom_req && rom_valid)
        take_event(K_FETCH, 16'(rom_addr), a_reg, d_reg, 0);
      else if (rom_req && !end_seen) begin
        end_seen = 1'b1;
        take_event(K_END, 16'(rom_addr), a_reg, d_reg, 0);
      end
      if (ram_wr) begin
        if (wr_cyc == 0) begin
          wr_a0 = ram_addr; wr_d0 = ram_wdata;
        end else if (ram_addr != wr_a0 || ram_wdata != wr_d0) begin
          flag("wr_unstable_cycle", wr_cyc);
        end
        wr_cyc++;
        if (ram_ready) begin
          take_event(K_WR, 16'(ram_addr), ram_wdata, 16'h0, wr_cyc);
          wr_cyc = 0;
        end
      end else wr_cyc = 0;
      if (ram_rd) begin
        rd_cyc++;
        if (ram_ready) begin
          take_event(K_RD, 16'(ram_addr), ram_rdata, 16'h0, rd_cyc);
          y_exp  = ram_rdata;
          y_pend = 1'b1;
          rd_cyc = 0;
        end
      end else rd_cyc = 0;
    end
  end

  task automatic enter_reset();
    @(negedge clk); #2;
    rst_n    = 1'b0;
    prog_len = 0;
  endtask

  task automatic wait_end(input string name);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #2;
      if (end_seen) break;
    end
    chk({name, "_reached_end"}, 32'(end_seen), 32'd1);
    chk({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    // Phase A: reset state, @5;D=A then @100;M=D with 2 wait cycles on the write
    add(15'd0, 16'h0005); add(15'd1, 16'hEC10); add(15'd2, 16'h0064); add(15'd3, 16'hE308);
    ram_delay = 2; pre_addr = 15'd100; pre_val = 16'h0000;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_rom_req", 32'(rom_req), 32'd0);
    chk("rst_ram_rd", 32'(ram_rd), 32'd0);
    chk("rst_ram_wr", 32'(ram_wr), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_a", 32'(a_reg), 32'd0);
    chk("rst_d", 32'(d_reg), 32'd0);
    push_f(K_FETCH, 1, 15'd0, 16'd0, 16'd0);
    push_f(K_FETCH, 3, 15'd1, 16'd5, 16'd0);
    push_f(K_FETCH, 6, 15'd2, 16'd5, 16'd5);
    push_f(K_FETCH, 8, 15'd3, 16'd100, 16'd5);
    push_m(K_WR, 13, 15'd100, 16'd5, 3);
    push_f(K_END, 14, 15'd4, 16'd100, 16'd5);
    rst_n = 1'b1;
    #1 chk("idle_rom_req", 32'(rom_req), 32'd0);
    @(posedge clk); #1;
    chk("first_fetch_req", 32'(rom_req), 32'd1);
    chk("first_fetch_addr", 32'(rom_addr), 32'd0);
    wait_end("phase_a");

    // Phase B: @100;D=M with M=0x1234 and 2 wait cycles on the read
    enter_reset();
    add(15'd0, 16'h0064); add(15'd1, 16'hFC10);
    ram_delay = 2; pre_addr = 15'd100; pre_val = 16'h1234;
    repeat (2) @(negedge clk);
    #2;
    push_f(K_FETCH, 1, 15'd0, 16'd0, 16'd0);
    push_f(K_FETCH, 3, 15'd1, 16'd100, 16'd0);
    push_m(K_RD, 7, 15'd100, 16'h1234, 3);
    push_f(K_END, 9, 15'd2, 16'd100, 16'h1234);
    rst_n = 1'b1;
    wait_end("phase_b");

    // Phase C: JGT taken/not taken, JEQ taken, JMP, and pc wrap at 0x7FFF
    enter_reset();
    add(15'd0, 16'h0005);  add(15'd1, 16'hEC10);  add(15'd2, 16'h0008);
    add(15'd3, 16'hE301);  add(15'd8, 16'hEA90);  add(15'd9, 16'h000E);
    add(15'd10, 16'hE301); add(15'd11, 16'hE302); add(15'd14, 16'h7FFF);
    add(15'd15, 16'hEA87); add(15'h7FFF, 16'h0003);
    ram_delay = 0; pre_addr = 15'd0; pre_val = 16'h0000;
    repeat (2) @(negedge clk);
    #2;
    push_f(K_FETCH, -1, 15'd0, 16'd0, 16'd0);
    push_f(K_FETCH, -1, 15'd1, 16'd5, 16'd0);
    push_f(K_FETCH, -1, 15'd2, 16'd5, 16'd5);
    push_f(K_FETCH, -1, 15'd3, 16'd8, 16'd5);
    push_f(K_FETCH, -1, 15'd8, 16'd8, 16'd5);
    push_f(K_FETCH, -1, 15'd9, 16'd8, 16'd0);
    push_f(K_FETCH, -1, 15'd10, 16'd14, 16'd0);
    push_f(K_FETCH, -1, 15'd11, 16'd14, 16'd0);
    push_f(K_FETCH, -1, 15'd14, 16'd14, 16'd0);
    push_f(K_FETCH, -1, 15'd15, 16'h7FFF, 16'd0);
    push_f(K_FETCH, -1, 15'h7FFF, 16'h7FFF, 16'd0);
    push_f(K_END, -1, 15'd0, 16'd3, 16'd0);
    rst_n = 1'b1;
    wait_end("phase_c");

    // Phase D: async reset while a write waits on a RAM that never answers
    enter_reset();
    add(15'd0, 16'h0007); add(15'd1, 16'hEC10); add(15'd2, 16'h0064); add(15'd3, 16'hE308);
    ram_delay = 1000; pre_addr = 15'd100; pre_val = 16'h0000;
    repeat (2) @(negedge clk);
    #2;
    push_f(K_FETCH, -1, 15'd0, 16'd0, 16'd0);
    push_f(K_FETCH, -1, 15'd1, 16'd7, 16'd0);
    push_f(K_FETCH, -1, 15'd2, 16'd7, 16'd7);
    push_f(K_FETCH, -1, 15'd3, 16'd100, 16'd7);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #2;
      if (ram_wr) break;
    end
    chk("abort_reached_mem_wr", 32'(ram_wr), 32'd1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ram_wr", 32'(ram_wr), 32'd0);
    chk("abort_rom_req", 32'(rom_req), 32'd0);
    chk("abort_ram_rd", 32'(ram_rd), 32'd0);
    chk("abort_pc", 32'(pc), 32'd0);
    chk("abort_a", 32'(a_reg), 32'd0);
    chk("abort_d", 32'(d_reg), 32'd0);
    repeat (2) @(negedge clk);
    #2;
    chk("abort_no_write", 32'(mem[100]), 32'd0);
    chk("abort_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
